id_stage_pipe: RTL and testbench

Parametrised, pipelined RISC-V decode stage. Successor to the single-cycle decoder: adds a registered ID/EX output with valid/ready handshake, flush, full I/S/B/U/J immediate generation, illegal-instruction detection, PC passthrough, and a configurable register file (RV32I or RV32E).
Sits between the IF pipeline register and EX; the writeback port comes from WB.

---
 rtl/id_stage_pipe_pkg.sv | 37 +++
 rtl/id_stage_pipe_if.sv | 46 ++++
 rtl/id_stage_pipe_regfile.sv | 49 ++++
 rtl/id_stage_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pipe_pkg.sv
// rv_id_pkg: shared constants for the pipelined RV32 decode stage.
//   - base opcodes (OP_*)
//   - 5-bit ALU operation codes (ALU_*)
//   - immediate format enum (imm_fmt_e)
package rv_id_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I       = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J_JAL   = 7'b1101111;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b10000;
    localparam logic [4:0] ALU_SLL  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b10111;
    localparam logic [4:0] ALU_SLTU = 5'b11000;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_SRA  = 5'b00110;
    localparam logic [4:0] ALU_OR   = 5'b00010;
    localparam logic [4:0] ALU_AND  = 5'b00001;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

endpackage

// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if: IF->ID->EX bus of the decode stage, plus the WB write port.
// Signal names are from the decode stage's point of view (i_* into it, o_* out of it).
//   slave  : decode stage side
//   master : environment side (IF/EX/WB or testbench)
interface id_stage_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_inst;
    logic [XLEN-1:0] i_pc;
    logic            i_flush;
    logic            i_wb_we;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_pc;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic [XLEN-1:0] o_imm;
    logic [4:0]      o_alu_ctrl;
    logic            o_alu_src;
    logic            o_regwrite;
    logic            o_memwrite;
    logic            o_memtoreg;
    logic            o_branch;
    logic            o_jal;
    logic            o_jalr;
    logic            o_illegal;

    modport slave (
        input  i_valid, i_inst, i_pc, i_flush, i_wb_we, i_wb_rd, i_wb_data, i_ready,
        output o_ready, o_valid, o_pc, o_rd, o_rs1_data, o_rs2_data, o_imm, o_alu_ctrl,
               o_alu_src, o_regwrite, o_memwrite, o_memtoreg, o_branch, o_jal, o_jalr,
               o_illegal
    );

    modport master (
        output i_valid, i_inst, i_pc, i_flush, i_wb_we, i_wb_rd, i_wb_data, i_ready,
        input  o_ready, o_valid, o_pc, o_rd, o_rs1_data, o_rs2_data, o_imm, o_alu_ctrl,
               o_alu_src, o_regwrite, o_memwrite, o_memtoreg, o_branch, o_jal, o_jalr,
               o_illegal
    );
endinterface

// File: rtl/id_stage_pipe_regfile.sv
// id_regfile: NREG x XLEN register file, 2 async read ports, 1 write port.
// Ports: i_clk, i_rst_n (async, active-low), i_we/i_wr_addr/i_wr_data (write),
//        i_rd_addr1/2 -> o_rd_data1/2 (combinational reads, x0 and out-of-range read 0).
// Macro ID_BYPASS_EN: a same-cycle write is forwarded to a matching read (write-first).
module id_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned RAW  = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [4:0]      i_rd_addr1,
    input  logic [4:0]      i_rd_addr2,
    output logic [XLEN-1:0] o_rd_data1,
    output logic [XLEN-1:0] o_rd_data2
);
    localparam logic [5:0] NREG_L = 6'(NREG);

    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_en;
    logic            w_rd1_ok;
    logic            w_rd2_ok;

    assign w_wr_en  = i_we && (|i_wr_addr) && ({1'b0, i_wr_addr} < NREG_L);
    assign w_rd1_ok = (|i_rd_addr1) && ({1'b0, i_rd_addr1} < NREG_L);
    assign w_rd2_ok = (|i_rd_addr2) && ({1'b0, i_rd_addr2} < NREG_L);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wr_en) begin
            r_regs[i_wr_addr[RAW-1:0]] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data1 = '0;
        o_rd_data2 = '0;
        if (w_rd1_ok) o_rd_data1 = r_regs[i_rd_addr1[RAW-1:0]];
        if (w_rd2_ok) o_rd_data2 = r_regs[i_rd_addr2[RAW-1:0]];
`ifdef ID_BYPASS_EN
        if (w_wr_en && (i_wr_addr == i_rd_addr1)) o_rd_data1 = i_wr_data;
        if (w_wr_en && (i_wr_addr == i_rd_addr2)) o_rd_data2 = i_wr_data;
`endif
    end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined RV32I/RV32E decode stage with registered ID/EX outputs.
// Ports: i_clk, i_rst_n (async, active-low), bus (id_stage_pipe_if.slave) carrying the
//        IF valid/ready/inst/pc/flush inputs, WB write port and all ID/EX outputs.
// Parameters: XLEN datapath width, NREG 32 (RV32I) or 16 (RV32E), RAW index width.
// Macro ID_BYPASS_EN: forward a same-edge WB write into the captured operands.
module id_stage_pipe
    import rv_id_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned RAW  = $clog2(NREG)
) (
    input logic           i_clk,
    input logic           i_rst_n,
    id_stage_pipe_if.slave bus
);
    logic [6:0]      w_opcode, w_funct7;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_funct3;
    imm_fmt_e        w_fmt;
    logic [4:0]      w_alu_fn, w_alu_ctrl;
    logic            w_alu_src, w_regwrite, w_memwrite, w_memtoreg, w_branch, w_jal, w_jalr;
    logic            w_illegal, w_use_rd, w_use_rs1, w_use_rs2;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
    logic            w_ready, w_capture;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rd, r_alu_ctrl;
    logic            r_alu_src, r_regwrite, r_memwrite, r_memtoreg, r_branch, r_jal, r_jalr;
    logic            r_illegal;

    assign w_opcode = bus.i_inst[6:0];
    assign w_rd     = bus.i_inst[11:7];
    assign w_funct3 = bus.i_inst[14:12];
    assign w_rs1    = bus.i_inst[19:15];
    assign w_rs2    = bus.i_inst[24:20];
    assign w_funct7 = bus.i_inst[31:25];

    id_regfile #(
        .XLEN(XLEN),
        .NREG(NREG),
        .RAW (RAW)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_we      (bus.i_wb_we),
        .i_wr_addr (bus.i_wb_rd),
        .i_wr_data (bus.i_wb_data),
        .i_rd_addr1(w_rs1),
        .i_rd_addr2(w_rs2),
        .o_rd_data1(w_rs1_data),
        .o_rd_data2(w_rs2_data)
    );

    // funct3 -> ALU op; funct7[5] selects SUB/SRA (caller masks it for ADDI).
    always_comb begin
        w_alu_fn = ALU_ADD;
        unique case (w_funct3)
            3'b000: w_alu_fn = w_funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001: w_alu_fn = ALU_SLL;
            3'b010: w_alu_fn = ALU_SLT;
            3'b011: w_alu_fn = ALU_SLTU;
            3'b100: w_alu_fn = ALU_XOR;
            3'b101: w_alu_fn = w_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_fn = ALU_OR;
            3'b111: w_alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        w_fmt      = ImmNone;
        w_alu_ctrl = ALU_ADD;
        w_alu_src  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_branch   = 1'b0;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_illegal  = 1'b0;
        w_use_rd   = 1'b0;
        w_use_rs1  = 1'b0;
        w_use_rs2  = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_alu_ctrl = w_alu_fn;
                w_regwrite = 1'b1;
                {w_use_rd, w_use_rs1, w_use_rs2} = 3'b111;
                if (w_funct7 == 7'b0100000) begin
                    w_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                end else begin
                    w_illegal = (w_funct7 != 7'b0000000);
                end
            end
            OP_I: begin
                w_fmt      = ImmI;
                w_alu_ctrl = (w_funct3 == 3'b000) ? ALU_ADD : w_alu_fn;
                w_alu_src  = 1'b1;
                w_regwrite = 1'b1;
                {w_use_rd, w_use_rs1} = 2'b11;
                // Shift-immediates reuse imm[11:5] as funct7.
                if (w_funct3 == 3'b001) w_illegal = (w_funct7 != 7'b0000000);
                if (w_funct3 == 3'b101) begin
                    w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                end
            end
            OP_I_LOAD: begin
                w_fmt      = ImmI;
                w_alu_src  = 1'b1;
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                {w_use_rd, w_use_rs1} = 2'b11;
            end
            OP_I_JALR: begin
                w_fmt      = ImmI;
                w_alu_src  = 1'b1;
                w_regwrite = 1'b1;
                w_jalr     = 1'b1;
                {w_use_rd, w_use_rs1} = 2'b11;
            end
            OP_S: begin
                w_fmt      = ImmS;
                w_alu_src  = 1'b1;
                w_memwrite = 1'b1;
                {w_use_rs1, w_use_rs2} = 2'b11;
            end
            OP_B: begin
                w_fmt      = ImmB;
                w_alu_ctrl = ALU_SUB;
                w_branch   = 1'b1;
                {w_use_rs1, w_use_rs2} = 2'b11;
            end
            OP_U_LUI, OP_U_AUIPC: begin
                w_fmt      = ImmU;
                w_alu_src  = 1'b1;
                w_regwrite = 1'b1;
                w_use_rd   = 1'b1;
            end
            OP_J_JAL: begin
                w_fmt      = ImmJ;
                w_alu_src  = 1'b1;
                w_regwrite = 1'b1;
                w_jal      = 1'b1;
                w_use_rd   = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        // RV32E only has x0..x15.
        if (NREG == 16) begin
            if ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4])) begin
                w_illegal = 1'b1;
            end
        end
        // Illegal entries still flow to EX (to trap) but must not cause side effects.
        if (w_illegal) begin
            w_regwrite = 1'b0;
            w_memwrite = 1'b0;
            w_branch   = 1'b0;
            w_jal      = 1'b0;
            w_jalr     = 1'b0;
        end
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            ImmI: w_imm32 = {{20{bus.i_inst[31]}}, bus.i_inst[31:20]};
            ImmS: w_imm32 = {{20{bus.i_inst[31]}}, bus.i_inst[31:25], bus.i_inst[11:7]};
            ImmB: w_imm32 = {{19{bus.i_inst[31]}}, bus.i_inst[31], bus.i_inst[7],
                             bus.i_inst[30:25], bus.i_inst[11:8], 1'b0};
            ImmU: w_imm32 = {bus.i_inst[31:12], 12'b0};
            ImmJ: w_imm32 = {{11{bus.i_inst[31]}}, bus.i_inst[31], bus.i_inst[19:12],
                             bus.i_inst[20], bus.i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm     = XLEN'($signed(w_imm32));
    assign w_ready   = !r_valid || bus.i_ready;
    assign w_capture = bus.i_valid && w_ready && !bus.i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alu_ctrl <= '0;
            r_alu_src  <= 1'b0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
            r_jal      <= 1'b0;
            r_jalr     <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (bus.i_flush) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (bus.i_ready) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                r_pc       <= bus.i_pc;
                r_rd       <= w_rd;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= w_imm;
                r_alu_ctrl <= w_alu_ctrl;
                r_alu_src  <= w_alu_src;
                r_regwrite <= w_regwrite;
                r_memwrite <= w_memwrite;
                r_memtoreg <= w_memtoreg;
                r_branch   <= w_branch;
                r_jal      <= w_jal;
                r_jalr     <= w_jalr;
                r_illegal  <= w_illegal;
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = r_valid;
    assign bus.o_pc       = r_pc;
    assign bus.o_rd       = r_rd;
    assign bus.o_rs1_data = r_rs1_data;
    assign bus.o_rs2_data = r_rs2_data;
    assign bus.o_imm      = r_imm;
    assign bus.o_alu_ctrl = r_alu_ctrl;
    assign bus.o_alu_src  = r_alu_src;
    assign bus.o_regwrite = r_regwrite;
    assign bus.o_memwrite = r_memwrite;
    assign bus.o_memtoreg = r_memtoreg;
    assign bus.o_branch   = r_branch;
    assign bus.o_jal      = r_jal;
    assign bus.o_jalr     = r_jalr;
    assign bus.o_illegal  = r_illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Testbench for id_stage_pipe: directed steps from the decode rules, then randomized
// traffic checked against an instruction-level reference model. A second instance with
// NREG=16 covers the RV32E illegal-register rule. Honours ID_BYPASS_EN when defined.
module tb_id_stage_pipe;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic        src;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32)) bus32 ();
    id_stage_pipe_if #(.XLEN(32)) bus16 ();

    id_stage_pipe #(.XLEN(32), .NREG(32)) u_dut32 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus32));
    id_stage_pipe #(.XLEN(32), .NREG(16)) u_dut16 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus16));

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    logic        m_valid = 1'b0;
    exp_t        m_out = '0;

    function automatic logic [4:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [4:0] tbl [8];
        tbl = '{5'b00000, 5'b00100, 5'b10111, 5'b11000, 5'b00011, 5'b00101, 5'b00010, 5'b00001};
        if (alt && f3 == 3'd0) return 5'b10000;
        if (alt && f3 == 3'd5) return 5'b00110;
        return tbl[f3];
    endfunction

    // Operand value seen at capture for a 32-register file.
    function automatic logic [31:0] op_val(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (bus32.i_wb_we && bus32.i_wb_rd == idx) return bus32.i_wb_data;
`endif
        return m_regs[idx];
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int iimm, simm, bimm, jimm;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        iimm = (inst[31] ? -2048 : 0) + int'(inst[30:20]);
        simm = (inst[31] ? -2048 : 0) + int'(inst[30:25]) * 32 + int'(inst[11:7]);
        bimm = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
             + int'(inst[11:8]) * 2;
        jimm = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
             + int'(inst[30:21]) * 2;
        e = '0;
        e.pc = pc;
        e.rd = inst[11:7];
        e.rs1 = op_val(inst[19:15]);
        e.rs2 = op_val(inst[24:20]);
        case (op)
            7'h33: begin
                e.alu = alu_code(f3, f7 == 7'h20);
                e.rw = 1'b1;
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                e.alu = (f3 == 3'd0) ? 5'b00000 : alu_code(f3, f7 == 7'h20);
                e.src = 1'b1; e.rw = 1'b1; e.imm = 32'(iimm);
                e.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h03: begin e.src = 1'b1; e.rw = 1'b1; e.m2r = 1'b1; e.imm = 32'(iimm); end
            7'h67: begin e.src = 1'b1; e.rw = 1'b1; e.jalr = 1'b1; e.imm = 32'(iimm); end
            7'h23: begin e.src = 1'b1; e.mw = 1'b1; e.imm = 32'(simm); end
            7'h63: begin e.alu = 5'b10000; e.br = 1'b1; e.imm = 32'(bimm); end
            7'h37, 7'h17: begin e.src = 1'b1; e.rw = 1'b1; e.imm = inst & 32'hFFFFF000; end
            7'h6F: begin e.src = 1'b1; e.rw = 1'b1; e.jal = 1'b1; e.imm = 32'(jimm); end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.rw = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jal = 1'b0; e.jalr = 1'b0;
        end
        return e;
    endfunction

    // Random legal RV32I instruction.
    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0]  ops [7];
        logic [31:0] inst;
        int k;
        r = $urandom();
        ops = '{7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        k = $urandom_range(0, 8);
        if (k == 0) begin
            inst = {7'h00, r[24:7], 7'h33};
            if ((r[14:12] == 3'd0 || r[14:12] == 3'd5) && r[30]) inst[31:25] = 7'h20;
        end else if (k == 1) begin
            inst = {r[31:7], 7'h13};
            if (r[14:12] == 3'd1) inst[31:25] = 7'h00;
            if (r[14:12] == 3'd5) inst[31:25] = r[30] ? 7'h20 : 7'h00;
        end else begin
            inst = {r[31:7], ops[k-2]};
        end
        return inst;
    endfunction

    function automatic exp_t observed32();
        exp_t o;
        o.pc = bus32.o_pc; o.rd = bus32.o_rd;
        o.rs1 = bus32.o_rs1_data; o.rs2 = bus32.o_rs2_data; o.imm = bus32.o_imm;
        o.alu = bus32.o_alu_ctrl; o.src = bus32.o_alu_src; o.rw = bus32.o_regwrite;
        o.mw = bus32.o_memwrite; o.m2r = bus32.o_memtoreg; o.br = bus32.o_branch;
        o.jal = bus32.o_jal; o.jalr = bus32.o_jalr; o.ill = bus32.o_illegal;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        exp_t o;
        o = observed32();
        n_checks++;
        assert (o === m_out) else begin
            n_fail++;
            $error("FAIL %s_fields: observed %h expected %h", tag, o, m_out);
        end
        chk({tag, "_valid"}, 32'(bus32.o_valid), 32'(m_valid));
        chk({tag, "_ready"}, 32'(bus32.o_ready), 32'(!m_valid || bus32.i_ready));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_out = '0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    endtask

    // One clock: predict from the inputs in force, advance, update model, sample at +1.
    task automatic tick();
        logic cap, nv;
        exp_t nxt;
        cap = bus32.i_valid && (!m_valid || bus32.i_ready) && !bus32.i_flush;
        nxt = ref_decode(bus32.i_inst, bus32.i_pc);
        nv = bus32.i_flush ? 1'b0 : cap ? 1'b1 : (m_valid && bus32.i_ready) ? 1'b0 : m_valid;
        @(posedge clk);
        #1;
        m_valid = nv;
        if (cap) m_out = nxt;
        if (bus32.i_wb_we && bus32.i_wb_rd != 5'd0) m_regs[bus32.i_wb_rd] = bus32.i_wb_data;
    endtask

    task automatic idle();
        bus32.i_valid = 1'b0; bus32.i_flush = 1'b0; bus32.i_wb_we = 1'b0; bus32.i_ready = 1'b1;
        bus16.i_valid = 1'b0; bus16.i_flush = 1'b0; bus16.i_wb_we = 1'b0; bus16.i_ready = 1'b1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        bus32.i_valid = 1'b1; bus32.i_inst = inst; bus32.i_pc = pc;
    endtask

    initial begin
        bus32.i_inst = '0; bus32.i_pc = '0; bus32.i_wb_rd = '0; bus32.i_wb_data = '0;
        bus16.i_inst = '0; bus16.i_pc = '0; bus16.i_wb_rd = '0; bus16.i_wb_data = '0;
        idle();
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // ADDI x1,x0,5
        send(32'h00500093, 32'h100);
        tick(); check_all("addi");
        chk("addi_imm", bus32.o_imm, 32'd5);
        chk("addi_alu", 32'(bus32.o_alu_ctrl), 32'h00);
        chk("addi_rw", 32'(bus32.o_regwrite), 32'd1);
        bus32.i_valid = 1'b0;

        // x1=7, x2=3 via WB
        bus32.i_wb_we = 1'b1; bus32.i_wb_rd = 5'd1; bus32.i_wb_data = 32'd7;
        tick(); check_all("wb1");
        bus32.i_wb_rd = 5'd2; bus32.i_wb_data = 32'd3;
        tick(); check_all("wb2");
        bus32.i_wb_we = 1'b0;

        send(32'h402081B3, 32'h104);
        tick(); check_all("sub");
        chk("sub_rs1", bus32.o_rs1_data, 32'd7);
        chk("sub_rs2", bus32.o_rs2_data, 32'd3);
        chk("sub_alu", 32'(bus32.o_alu_ctrl), 32'h10);
        chk("sub_src", 32'(bus32.o_alu_src), 32'd0);

        send(32'h0020A423, 32'h108);
        tick(); check_all("sw");
        chk("sw_imm", bus32.o_imm, 32'd8);
        chk("sw_mw", 32'(bus32.o_memwrite), 32'd1);
        chk("sw_rw", 32'(bus32.o_regwrite), 32'd0);

        send(32'hFE208EE3, 32'h10C);
        tick(); check_all("beq");
        chk("beq_imm", bus32.o_imm, 32'hFFFFFFFC);
        chk("beq_br", 32'(bus32.o_branch), 32'd1);

        // Stall with a new instruction pending, then flush.
        bus32.i_ready = 1'b0;
        send(32'h00100113, 32'h110);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("stall");
            chk("stall_ready", 32'(bus32.o_ready), 32'd0);
            chk("stall_imm", bus32.o_imm, 32'hFFFFFFFC);
        end
        bus32.i_flush = 1'b1;
        tick(); check_all("flush");
        chk("flush_valid", 32'(bus32.o_valid), 32'd0);
        idle();

        // WB write on the capture edge.
        bus32.i_wb_we = 1'b1; bus32.i_wb_rd = 5'd5; bus32.i_wb_data = 32'hA5A5A5A5;
        send(32'h00028313, 32'h114);
        tick(); check_all("byp");
`ifdef ID_BYPASS_EN
        chk("byp_rs1", bus32.o_rs1_data, 32'hA5A5A5A5);
`else
        chk("byp_rs1", bus32.o_rs1_data, 32'd0);
`endif
        bus32.i_wb_rd = 5'd0; bus32.i_wb_data = 32'hFFFFFFFF;
        send(32'h00000033, 32'h118);
        tick(); check_all("x0w");
        chk("x0_rs1", bus32.o_rs1_data, 32'd0);
        idle();
        tick(); check_all("x0_after");

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            bus32.i_valid = ($urandom_range(0, 3) != 0);
            bus32.i_ready = ($urandom_range(0, 3) != 0);
            bus32.i_flush = ($urandom_range(0, 15) == 0);
            bus32.i_inst = gen_inst();
            bus32.i_pc = $urandom();
            bus32.i_wb_we = 1'($urandom_range(0, 1));
            bus32.i_wb_rd = 5'($urandom_range(0, 31));
            bus32.i_wb_data = $urandom();
            tick(); check_all("rand");
        end
        idle();
        tick(); check_all("drain");

        // RV32E: rd=x16 is illegal; unknown opcode illegal on both.
        bus16.i_valid = 1'b1; bus16.i_inst = 32'h00F00813;
        tick(); check_all("e_idle");
        chk("e_x16_ill", 32'(bus16.o_illegal), 32'd1);
        chk("e_x16_rw", 32'(bus16.o_regwrite), 32'd0);
        chk("e_x16_valid", 32'(bus16.o_valid), 32'd1);
        bus16.i_inst = 32'h00500093;
        tick(); check_all("e_idle2");
        chk("e_addi_ill", 32'(bus16.o_illegal), 32'd0);
        chk("e_addi_rw", 32'(bus16.o_regwrite), 32'd1);
        bus16.i_inst = 32'h0000007F;
        send(32'h0000007F, 32'h200);
        tick(); check_all("unk");
        chk("e_unk_ill", 32'(bus16.o_illegal), 32'd1);
        chk("unk_ill", 32'(bus32.o_illegal), 32'd1);
        idle();

        // Reset while stalled: entry dropped immediately.
        send(32'h00500093, 32'h300);
        tick(); check_all("pre_rst");
        bus32.i_valid = 1'b0; bus32.i_ready = 1'b0;
        tick(); check_all("pre_rst_stall");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_valid", 32'(bus32.o_valid), 32'd0);
        check_all("rst_async");
        @(negedge clk) rst_n = 1'b1;
        idle();
        send(32'h002081B3, 32'h304);
        tick(); check_all("post_rst");
        chk("post_rst_rs1", bus32.o_rs1_data, 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
